// File: rtl/line_arbiter.sv
// line_arbiter: N-master round-robin arbiter that serialises cache-line
// reads/writes onto a single downstream memory/MMU port and returns line
// data, page entry and fault status to the granted master.
// Optional macro ARB_TIMEOUT_EN adds a BUSY watchdog of TIMEOUT_CYCLES.
module line_arbiter #(
   parameter int unsigned NUM_MASTERS    = 2,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned LINE_WIDTH     = 256,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
   input  logic [NUM_MASTERS*LINE_WIDTH-1:0] m_data_i,
   input  logic [NUM_MASTERS-1:0]            m_rd_i,
   input  logic [NUM_MASTERS-1:0]            m_we_i,
   output logic [LINE_WIDTH-1:0]             m_data_o,
   output logic [31:0]                       m_page_ent_o,
   output logic [NUM_MASTERS-1:0]            m_ack_o,
   output logic [NUM_MASTERS-1:0]            m_fault_o,
   output logic [NUM_MASTERS-1:0]            grant_o,
   output logic [ADDR_WIDTH-1:0]             addr_o,
   output logic [LINE_WIDTH-1:0]             data_o,
   output logic                              rd_o,
   output logic                              we_o,
   input  logic [LINE_WIDTH-1:0]             data_i,
   input  logic [31:0]                       page_ent_i,
   input  logic                              ack_i,
   input  logic                              hw_page_fault_i
);

   localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_e;

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        ptr_q, ptr_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    is_wr_q, is_wr_d;
   logic [LINE_WIDTH-1:0]   rdata_q, rdata_d;
   logic [31:0]             pent_q, pent_d;
   logic                    fault_q, fault_d;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]        cnt_q, cnt_d;
`endif

   // Per-master views of the flattened request buses
   logic [NUM_MASTERS-1:0]  req;
   logic [ADDR_WIDTH-1:0]   addr_arr [NUM_MASTERS];
   logic [LINE_WIDTH-1:0]   data_arr [NUM_MASTERS];

   assign req = m_rd_i | m_we_i;

   for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
      assign addr_arr[g] = m_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign data_arr[g] = m_data_i[g*LINE_WIDTH +: LINE_WIDTH];
   end

   logic                    pick_valid;
   logic [IDX_W-1:0]        pick_idx;
   logic [NUM_MASTERS-1:0]  owner_oh;

   assign owner_oh = NUM_MASTERS'(1) << idx_q;

   // Round-robin pick: first requester at or after the pointer, wrapping
   always_comb begin
      logic [IDX_W:0] cand;
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
         if (cand >= (IDX_W+1)'(NUM_MASTERS)) begin
            cand = cand - (IDX_W+1)'(NUM_MASTERS);
         end
         if (!pick_valid && req[cand[IDX_W-1:0]]) begin
            pick_valid = 1'b1;
            pick_idx   = cand[IDX_W-1:0];
         end
      end
   end

   // Next-state logic for the transaction FSM and its captured fields
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      is_wr_d = is_wr_q;
      rdata_d = rdata_q;
      pent_d  = pent_q;
      fault_d = fault_q;
`ifdef ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               idx_d   = pick_idx;
               addr_d  = addr_arr[pick_idx];
               wdata_d = data_arr[pick_idx];
               // write wins when both strobes are raised together
               is_wr_d = m_we_i[pick_idx];
               state_d = BUSY;
`ifdef ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         BUSY: begin
            if (ack_i) begin
               rdata_d = data_i;
               pent_d  = page_ent_i;
               fault_d = hw_page_fault_i;
               state_d = DONE;
            end
`ifdef ARB_TIMEOUT_EN
            // ack on the expiry cycle still completes normally (checked first)
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               rdata_d = '0;
               pent_d  = '0;
               fault_d = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         DONE: begin
            ptr_d   = (idx_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : idx_q + 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         is_wr_q <= 1'b0;
         rdata_q <= '0;
         pent_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         is_wr_q <= is_wr_d;
         rdata_q <= rdata_d;
         pent_q  <= pent_d;
         fault_q <= fault_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   // BUSY watchdog counter
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   // Output decode from the registered state
   always_comb begin
      m_ack_o   = '0;
      m_fault_o = '0;
      grant_o   = '0;
      rd_o      = 1'b0;
      we_o      = 1'b0;
      addr_o    = '0;
      data_o    = '0;
      case (state_q)
         BUSY: begin
            grant_o = owner_oh;
            rd_o    = ~is_wr_q;
            we_o    = is_wr_q;
            addr_o  = addr_q;
            data_o  = wdata_q;
         end
         DONE: begin
            grant_o   = owner_oh;
            m_ack_o   = owner_oh;
            m_fault_o = fault_q ? owner_oh : '0;
         end
         default: begin
         end
      endcase
   end

   assign m_data_o     = rdata_q;
   assign m_page_ent_o = pent_q;

endmodule

// File: tb/tb_line_arbiter.sv
// tb_line_arbiter: scoreboard bench for line_arbiter (3 masters).
// Stimulus pushes expected downstream requests and master acks into queues;
// a monitor pops and compares whenever the DUT presents them.
// Build with ARB_TIMEOUT_EN to exercise the watchdog (TIMEOUT_CYCLES=16).
module tb_line_arbiter;

   localparam int N  = 3;
   localparam int AW = 32;
   localparam int LW = 256;

   logic            clk;
   logic            rst;
   logic [N*AW-1:0] m_addr_i;
   logic [N*LW-1:0] m_data_i;
   logic [N-1:0]    m_rd_i;
   logic [N-1:0]    m_we_i;
   logic [LW-1:0]   m_data_o;
   logic [31:0]     m_page_ent_o;
   logic [N-1:0]    m_ack_o;
   logic [N-1:0]    m_fault_o;
   logic [N-1:0]    grant_o;
   logic [AW-1:0]   addr_o;
   logic [LW-1:0]   data_o;
   logic            rd_o;
   logic            we_o;
   logic [LW-1:0]   data_i;
   logic [31:0]     page_ent_i;
   logic            ack_i;
   logic            hw_page_fault_i;

   line_arbiter #(
      .NUM_MASTERS   (N),
      .ADDR_WIDTH    (AW),
      .LINE_WIDTH    (LW),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .m_addr_i       (m_addr_i),
      .m_data_i       (m_data_i),
      .m_rd_i         (m_rd_i),
      .m_we_i         (m_we_i),
      .m_data_o       (m_data_o),
      .m_page_ent_o   (m_page_ent_o),
      .m_ack_o        (m_ack_o),
      .m_fault_o      (m_fault_o),
      .grant_o        (grant_o),
      .addr_o         (addr_o),
      .data_o         (data_o),
      .rd_o           (rd_o),
      .we_o           (we_o),
      .data_i         (data_i),
      .page_ent_i     (page_ent_i),
      .ack_i          (ack_i),
      .hw_page_fault_i(hw_page_fault_i)
   );

   typedef struct {
      logic [N-1:0]  ack;
      logic [N-1:0]  fault;
      logic [LW-1:0] data;
      logic [31:0]   pent;
      bit            chk_data;
      int            gap;
   } ack_t;

   typedef struct {
      logic [N-1:0]  grant;
      logic [AW-1:0] addr;
      bit            we;
      logic [LW-1:0] data;
   } ds_t;

   ack_t ack_q[$];
   ds_t  ds_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   last_ack = 0;
   logic prev_stb = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops expectations when a downstream request starts or an ack appears
   initial begin
      ack_t a;
      ds_t  d;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if ((rd_o | we_o) && !prev_stb) begin
            if (ds_q.size() == 0) begin
               chk("ds_unexpected", {rd_o, we_o}, 0);
            end else begin
               d = ds_q.pop_front();
               chk("ds_grant", grant_o, d.grant);
               chk("ds_addr", addr_o, d.addr);
               chk("ds_we", we_o, d.we);
               chk("ds_rd", rd_o, !d.we);
               if (d.we) chk("ds_wdata", data_o, d.data);
            end
         end
         prev_stb = rd_o | we_o;
         if (m_ack_o != '0) begin
            if (ack_q.size() == 0) begin
               chk("ack_unexpected", m_ack_o, 0);
            end else begin
               a = ack_q.pop_front();
               chk("ack_onehot", m_ack_o, a.ack);
               chk("ack_fault", m_fault_o, a.fault);
               chk("ack_pent", m_page_ent_o, a.pent);
               if (a.chk_data) chk("ack_data", m_data_o, a.data);
               if (a.gap > 0) chk("ack_gap", cyc - last_ack, a.gap);
            end
            last_ack = cyc;
         end
      end
   end

   // One transaction from master k; downstream acks in the nbusy-th BUSY cycle
   task automatic xact(input int k, input logic [AW-1:0] addr, input logic [LW-1:0] wdata,
                       input bit rd, input bit we, input int nbusy,
                       input logic [LW-1:0] rdata, input logic [31:0] pent, input bit flt);
      ack_t a;
      ds_t  d;
      @(negedge clk);
      m_addr_i[k*AW +: AW] = addr;
      m_data_i[k*LW +: LW] = wdata;
      m_rd_i[k] = rd;
      m_we_i[k] = we;
      d.grant = N'(1) << k;
      d.addr  = addr;
      d.we    = we;
      d.data  = wdata;
      ds_q.push_back(d);
      a.ack      = N'(1) << k;
      a.fault    = flt ? a.ack : '0;
      a.data     = rdata;
      a.pent     = pent;
      a.chk_data = !we;
      a.gap      = 0;
      ack_q.push_back(a);
      for (int i = 1; i <= nbusy; i++) begin
         @(negedge clk);
         chk("strobe_busy", we ? we_o : rd_o, 1);
         chk("strobe_other", we ? rd_o : we_o, 0);
         if (i == nbusy) begin
            ack_i           = 1'b1;
            data_i          = rdata;
            page_ent_i      = pent;
            hw_page_fault_i = flt;
         end
      end
      @(negedge clk);
      ack_i           = 1'b0;
      hw_page_fault_i = 1'b0;
      m_rd_i[k]       = 1'b0;
      m_we_i[k]       = 1'b0;
      chk("strobe_drop", rd_o | we_o, 0);
      chk("ack_latency", m_ack_o, N'(1) << k);
      @(negedge clk);
      chk("ack_single", m_ack_o, 0);
   endtask

   initial begin
      ack_t a;
      ds_t  d;
      int   cnt;
      rst = 1'b1;
      m_addr_i = '0;
      m_data_i = '0;
      m_rd_i = '0;
      m_we_i = '0;
      data_i = '0;
      page_ent_i = '0;
      ack_i = 1'b0;
      hw_page_fault_i = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_strobes", {rd_o, we_o, m_ack_o, m_fault_o, grant_o}, 0);
      chk("rst_addr", addr_o, 0);
      chk("rst_wdata", data_o, 0);
      chk("rst_mdata", m_data_o, 0);
      chk("rst_pent", m_page_ent_o, 0);
      rst = 1'b0;

      // basic read, 4 BUSY cycles
      xact(0, 32'h0000_1000, '0, 1, 0, 4, {8{32'hA5A5_A5A5}}, 32'hFFFF_FFFF, 0);
      chk("data_retained", m_data_o, {8{32'hA5A5_A5A5}});
      // rd+we together resolves to a write
      xact(1, 32'h0000_2000, 256'h1234, 1, 1, 2, {8{32'h5555_0000}}, 32'h0000_ABCD, 0);
      // faulting read for master1 (pointer at 2, wraps around to 1)
      xact(1, 32'h0000_3000, '0, 1, 0, 1, {8{32'hDEAD_BEEF}}, 32'h0000_1111, 1);

      // reset in BUSY, then a stray ack in IDLE
      @(negedge clk);
      m_addr_i[2*AW +: AW] = 32'h0000_4000;
      m_rd_i[2] = 1'b1;
      d.grant = 3'b100; d.addr = 32'h0000_4000; d.we = 0; d.data = '0;
      ds_q.push_back(d);
      @(negedge clk);
      chk("rst_pre_rd", rd_o, 1);
      rst = 1'b1;
      m_rd_i = '0;
      @(negedge clk);
      chk("rst_rd_drop", rd_o, 0);
      chk("rst_grant", grant_o, 0);
      rst = 1'b0;
      @(negedge clk);
      ack_i = 1'b1;
      data_i = {8{32'h7777_7777}};
      page_ent_i = 32'h7777_7777;
      @(negedge clk);
      ack_i = 1'b0;
      chk("stray_no_ack", m_ack_o, 0);
      chk("stray_idle", rd_o | we_o, 0);
      @(negedge clk);
      chk("stray_no_ack2", m_ack_o, 0);

      // fairness: all masters request, ack held high (ignored outside BUSY)
      m_addr_i = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
      m_rd_i = 3'b111;
      ack_i = 1'b1;
      data_i = {8{32'h0BAD_F00D}};
      page_ent_i = 32'hCAFE_0001;
      for (int i = 0; i < 4; i++) begin
         d.grant = N'(1) << (i % 3);
         d.addr  = 32'(((i % 3) + 1) * 256);
         d.we    = 0;
         d.data  = '0;
         ds_q.push_back(d);
         a.ack = N'(1) << (i % 3);
         a.fault = '0;
         a.data = {8{32'h0BAD_F00D}};
         a.pent = 32'hCAFE_0001;
         a.chk_data = 1;
         a.gap = (i == 0) ? 0 : 3;
         ack_q.push_back(a);
      end
      repeat (11) @(negedge clk);
      ack_i = 1'b0;
      m_rd_i = '0;
      repeat (3) @(negedge clk);

      // watchdog: downstream never acks
      @(negedge clk);
      m_addr_i[0 +: AW] = 32'h0000_5000;
      m_rd_i[0] = 1'b1;
      d.grant = 3'b001; d.addr = 32'h0000_5000; d.we = 0; d.data = '0;
      ds_q.push_back(d);
`ifdef ARB_TIMEOUT_EN
      a.ack = 3'b001; a.fault = 3'b001; a.data = '0; a.pent = 32'h0;
      a.chk_data = 1; a.gap = 0;
      ack_q.push_back(a);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!rd_o) break;
         cnt++;
      end
      m_rd_i = '0;
      chk("timeout_busy_cycles", cnt, 16);
`else
      a.ack = 3'b001; a.fault = '0; a.data = {8{32'h3C3C_3C3C}}; a.pent = 32'h0000_3C3C;
      a.chk_data = 1; a.gap = 0;
      ack_q.push_back(a);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rd_o) cnt++;
      end
      chk("no_timeout_busy", cnt, 40);
      ack_i = 1'b1;
      data_i = {8{32'h3C3C_3C3C}};
      page_ent_i = 32'h0000_3C3C;
      @(negedge clk);
      ack_i = 1'b0;
      m_rd_i = '0;
`endif
      @(negedge clk);

      for (int i = 0; i < 20 && (ack_q.size() != 0 || ds_q.size() != 0); i++) @(negedge clk);
      chk("ack_queue_drained", ack_q.size(), 0);
      chk("ds_queue_drained", ds_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/line_arbiter.md
Name: line_arbiter

Overview:
- Parametrised N-master round-robin arbiter for cache-line transactions; successor to the fixed two-port (icache/dcache) arbiter.
- Sits between the L1 caches and other line masters (page walker, DMA) and the single memory/MMU port.
- Serialises one line read or write at a time.
- Returns line data, page-table entry and page-fault status to the granted master.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8)
- ADDR_WIDTH, 32, address width
- LINE_WIDTH, 256, cache-line data width
- TIMEOUT_CYCLES, 1024, BUSY-state watchdog limit (used only with ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m_addr_i  in  NUM_MASTERS*ADDR_WIDTH  per-master line address; master k occupies slice k
- m_data_i  in  NUM_MASTERS*LINE_WIDTH  per-master write line
- m_rd_i  in  NUM_MASTERS  per-master read request
- m_we_i  in  NUM_MASTERS  per-master write request
- m_data_o  out  LINE_WIDTH  read data, broadcast to all masters, valid with ack
- m_page_ent_o  out  32  page entry, broadcast, valid with ack
- m_ack_o  out  NUM_MASTERS  one-hot completion pulse
- m_fault_o  out  NUM_MASTERS  one-hot page-fault flag, coincident with ack
- grant_o  out  NUM_MASTERS  one-hot current owner, zero when idle
- addr_o  out  ADDR_WIDTH  downstream address
- data_o  out  LINE_WIDTH  downstream write line
- rd_o  out  1  downstream read strobe
- we_o  out  1  downstream write strobe
- data_i  in  LINE_WIDTH  downstream read line
- page_ent_i  in  32  downstream page entry
- ack_i  in  1  downstream completion
- hw_page_fault_i  in  1  downstream fault, sampled with ack_i

Behaviour:
- Clock and reset: single clock clk; synchronous active-high rst.
- Reset state: all outputs 0; state IDLE; round-robin pointer 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Request from master k = m_rd_i[k] | m_we_i[k].
  - If any request is present, pick the first requester at or after the pointer, wrapping modulo NUM_MASTERS.
  - Latch that master's index, address, write line and type; go to BUSY.
  - If m_we_i and m_rd_i are both high, the transaction is a write.
  - No request: stay in IDLE.
- BUSY:
  - Drive addr_o/data_o from the latched values; rd_o or we_o held high; grant_o one-hot.
  - Stay until ack_i.
  - On ack_i: register data_i, page_ent_i and hw_page_fault_i.
  - Same edge: drop rd_o/we_o; go to DONE.
- DONE (exactly 1 cycle):
  - m_ack_o[idx]=1; m_fault_o[idx]=hw_page_fault_i as captured.
  - m_data_o/m_page_ent_o hold the captured values.
  - Pointer updates to idx+1, wrapping to 0 after NUM_MASTERS-1.
  - Go to IDLE. Requests are not sampled in DONE.
- Latency: a request in IDLE at cycle t gives rd_o/we_o at t+1. Downstream ack at cycle u gives m_ack_o at u+1. Minimum 3 cycles from request to ack.
- Master rule: drop the request on the edge that samples m_ack_o, so the following IDLE cycle does not re-grant the same transaction.
- m_data_o/m_page_ent_o retain their last values after DONE. Masters use them only while their own ack is high.
- A master withdrawing its request during BUSY: the transaction still completes and the ack is still pulsed.
- Writes: the ack still captures page_ent_i and the fault flag; data_i capture is don't-care.
- Fairness: with all masters continuously requesting, grants rotate 0,1,…,N-1,0. No master waits more than N-1 transactions.
- rst in BUSY or DONE: rd_o/we_o/m_ack_o low on the next edge; state IDLE; pointer 0. A late ack_i after reset is ignored in IDLE.
- ack_i outside BUSY is ignored.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in BUSY, cleared on entry.
  - If it reaches TIMEOUT_CYCLES without ack_i, drop rd_o/we_o and go to DONE.
  - In that DONE: m_ack_o[idx]=1, m_fault_o[idx]=1, m_data_o=0, m_page_ent_o=0.
  - An ack_i on the same cycle as expiry wins; the transaction completes normally.
- Undefined: no counter; BUSY waits for ack_i indefinitely; TIMEOUT_CYCLES unused.

Test Plan:
- N=2, master0 reads 0x0000_1000; downstream acks 4 cycles later with data_i=256'hA5…A5, page_ent_i=0xFFFF_FFFF, fault=0 -> rd_o high for 4 cycles; m_ack_o=2'b01 for one cycle with m_data_o=A5…A5; m_fault_o=0.
- N=3, all three masters request continuously with 1-cycle downstream ack -> grant_o sequence 001,010,100,001; each ack 3 cycles apart.
- Master1 asserts m_rd_i and m_we_i with m_data_i=256'h1234 -> we_o=1, rd_o=0, data_o=256'h1234.
- Downstream returns hw_page_fault_i=1 with ack for master1 read -> m_fault_o=2'b10 and m_ack_o=2'b10 in the same single cycle.
- rst asserted mid-BUSY, then a stray ack_i 2 cycles later -> rd_o low after 1 edge; no m_ack_o pulse; next grant goes to master0.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, downstream never acks -> rd_o drops after 16 BUSY cycles; m_ack_o and m_fault_o pulse for the owner; m_data_o=0.
